// File: rtl/hw_dispatch_pkg.sv
// Shared types for the core-side dispatch pop controller.
package hw_dispatch_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} pop_state_e;

endpackage

// File: rtl/hw_dispatch_pop_fsm.sv
// One pop channel: request/wait/respond FSM, captured value and saturating wait counter.
module hw_dispatch_pop_fsm
  import hw_dispatch_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  output logic              gnt_o,
  output logic              rvalid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              pop_req_o,
  output logic              pop_ack_o,
  input  logic [DATA_W-1:0] value_i,
  input  logic              event_i,
  input  logic              clr_i,
  output logic [CNT_W-1:0]  wait_cnt_o
);

  pop_state_e        state_q, state_d;
  logic [DATA_W-1:0] rdata_q;
  logic [CNT_W-1:0]  cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // RESP always falls back to IDLE, so consecutive pop_req pulses are at
  // least three cycles apart; the dispatch read pointer relies on that gap.
  always_comb begin
    state_d   = state_q;
    gnt_o     = 1'b0;
    pop_req_o = 1'b0;
    pop_ack_o = 1'b0;
    rvalid_o  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // gated by reset so a held request cannot leak out while in reset
        if (req_i && rst_ni) begin
          gnt_o     = 1'b1;
          pop_req_o = 1'b1;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (event_i) begin
          pop_ack_o = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        rvalid_o = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      if (pop_ack_o) rdata_q <= value_i;
      if (clr_i)                                 cnt_q <= '0;
      else if (state_q == WAIT && cnt_q != '1)   cnt_q <= cnt_q + 1'b1;
    end
  end

  assign rdata_o    = rdata_q;
  assign wait_cnt_o = cnt_q;

endmodule

// File: rtl/hw_dispatch_pop_ctrl.sv
// Core-side consumer of the HW dispatch unit: one independent pop channel per core.
module hw_dispatch_pop_ctrl
  import hw_dispatch_pkg::*;
#(
  parameter int NB_CORES = 4,
  parameter int CNT_W    = 16
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NB_CORES-1:0]                core_req_i,
  output logic [NB_CORES-1:0]                core_gnt_o,
  output logic [NB_CORES-1:0]                core_rvalid_o,
  output logic [NB_CORES-1:0][DATA_W-1:0]    core_rdata_o,
  output logic [NB_CORES-1:0]                pop_req_o,
  output logic [NB_CORES-1:0]                pop_ack_o,
  input  logic [NB_CORES-1:0][DATA_W-1:0]    dispatch_value_i,
  input  logic [NB_CORES-1:0]                dispatch_event_i,
  input  logic [NB_CORES-1:0]                stat_clr_i,
  output logic [NB_CORES-1:0][CNT_W-1:0]     stat_wait_cnt_o
);

  for (genvar g = 0; g < NB_CORES; g++) begin : g_ch
    hw_dispatch_pop_fsm #(
      .CNT_W(CNT_W)
    ) u_fsm (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .req_i      (core_req_i[g]),
      .gnt_o      (core_gnt_o[g]),
      .rvalid_o   (core_rvalid_o[g]),
      .rdata_o    (core_rdata_o[g]),
      .pop_req_o  (pop_req_o[g]),
      .pop_ack_o  (pop_ack_o[g]),
      .value_i    (dispatch_value_i[g]),
      .event_i    (dispatch_event_i[g]),
      .clr_i      (stat_clr_i[g]),
      .wait_cnt_o (stat_wait_cnt_o[g])
    );
  end

endmodule

// File: tb/tb_hw_dispatch_pop_ctrl.sv
// Bench for hw_dispatch_pop_ctrl paired with a behavioural dispatch unit model.
module tb_hw_dispatch_pop_ctrl;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  logic [3:0]       core_req = '0, stat_clr = '0, tbl_ev = '0, m_ev;
  logic [3:0][31:0] tbl_val = '0, m_val;
  logic [3:0]       disp_ev;
  logic [3:0][31:0] disp_val;
  logic             model_en = 1'b0, chk_en = 1'b0;
  logic             push_vld = 1'b0;
  logic [31:0]      push_val = '0;
  logic [3:0]       push_team = '0;

  logic [3:0]       gnt, rv, pop, ack, gnt4, rv4, pop4, ack4;
  logic [3:0][31:0] rdata, rdata4;
  logic [3:0][15:0] cnt;
  logic [3:0][3:0]  cnt4;

  assign disp_ev  = model_en ? m_ev  : tbl_ev;
  assign disp_val = model_en ? m_val : tbl_val;

  hw_dispatch_pop_ctrl #(.NB_CORES(4), .CNT_W(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .core_req_i(core_req), .core_gnt_o(gnt),
    .core_rvalid_o(rv), .core_rdata_o(rdata), .pop_req_o(pop), .pop_ack_o(ack),
    .dispatch_value_i(disp_val), .dispatch_event_i(disp_ev), .stat_clr_i(stat_clr),
    .stat_wait_cnt_o(cnt));

  hw_dispatch_pop_ctrl #(.NB_CORES(4), .CNT_W(4)) dut4 (
    .clk_i(clk_i), .rst_ni(rst_ni), .core_req_i(core_req), .core_gnt_o(gnt4),
    .core_rvalid_o(rv4), .core_rdata_o(rdata4), .pop_req_o(pop4), .pop_ack_o(ack4),
    .dispatch_value_i(disp_val), .dispatch_event_i(disp_ev), .stat_clr_i(stat_clr),
    .stat_wait_cnt_o(cnt4));

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors < 40) $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Dispatch unit model: per-core queue of values addressed to that core;
  // the read pointer moves two cycles after the ack, as in the real unit.
  logic [31:0] q [4][$];
  int          cd [4];
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < 4; c++) begin
        q[c].delete();
        cd[c] <= 0;
      end
      m_ev  <= '0;
      m_val <= '0;
    end else begin
      for (int c = 0; c < 4; c++) begin
        if (cd[c] == 1 && q[c].size() > 0) void'(q[c].pop_front());
        if (ack[c])          cd[c] <= 2;
        else if (cd[c] != 0) cd[c] <= cd[c] - 1;
        if (push_vld && push_team[c]) q[c].push_back(push_val);
        m_ev[c]  <= (q[c].size() != 0);
        m_val[c] <= (q[c].size() != 0) ? q[c][0] : 32'h0;
      end
    end
  end

  // Reference: expected values per core in push order, plus protocol rules
  // (grant only when no transfer outstanding, ack only while waiting with an
  // event, response exactly one cycle after ack, counter = saturated wait cycles).
  logic [31:0] exp_q [4][$];
  int          pop_log [4][$];
  int          ack_log [4][$];
  logic [31:0] rv_log  [4][$];
  logic [3:0]  wflag, rvdue;
  int          ref16 [4], ref4 [4];
  logic        eg, ea;
  logic [31:0] ed;

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      wflag <= '0;
      rvdue <= '0;
      for (int c = 0; c < 4; c++) begin
        ref16[c] <= 0;
        ref4[c]  <= 0;
      end
    end else if (chk_en) begin
      for (int c = 0; c < 4; c++) begin
        eg = core_req[c] && !wflag[c] && !rvdue[c];
        ea = wflag[c] && disp_ev[c];
        chk("gnt", gnt[c], eg);
        chk("pop_req", pop[c], eg);
        chk("pop_ack", ack[c], ea);
        chk("rvalid", rv[c], rvdue[c]);
        chk("gnt_w4", gnt4[c], eg);
        chk("pop_req_w4", pop4[c], eg);
        chk("pop_ack_w4", ack4[c], ea);
        chk("rvalid_w4", rv4[c], rvdue[c]);
        if (rv[c]) begin
          chk("rdata_avail", exp_q[c].size() != 0, 1);
          if (exp_q[c].size() != 0) begin
            ed = exp_q[c].pop_front();
            chk("rdata", rdata[c], ed);
            chk("rdata_w4", rdata4[c], ed);
          end
          rv_log[c].push_back(rdata[c]);
        end
        chk("wait_cnt", cnt[c], ref16[c]);
        chk("wait_cnt_w4", cnt4[c], ref4[c]);
        if (stat_clr[c]) begin
          ref16[c] <= 0;
          ref4[c]  <= 0;
        end else if (wflag[c]) begin
          ref16[c] <= (ref16[c] < 65535) ? ref16[c] + 1 : ref16[c];
          ref4[c]  <= (ref4[c] < 15) ? ref4[c] + 1 : ref4[c];
        end
        wflag[c] <= eg ? 1'b1 : (ea ? 1'b0 : wflag[c]);
        rvdue[c] <= ea;
        if (pop[c]) pop_log[c].push_back(cyc);
        if (ack[c]) ack_log[c].push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_logs();
    for (int c = 0; c < 4; c++) begin
      pop_log[c].delete();
      ack_log[c].delete();
      rv_log[c].delete();
    end
  endtask

  task automatic do_reset();
    rst_ni   = 1'b0;
    core_req = '0;
    stat_clr = '0;
    push_vld = 1'b0;
    for (int c = 0; c < 4; c++) exp_q[c].delete();
    clear_logs();
    repeat (2) tick();
    rst_ni = 1'b1;
  endtask

  task automatic set_push(input logic [31:0] v, input logic [3:0] t);
    push_vld  = 1'b1;
    push_val  = v;
    push_team = t;
    for (int c = 0; c < 4; c++) if (t[c]) exp_q[c].push_back(v);
  endtask

  task automatic push(input logic [31:0] v, input logic [3:0] t);
    set_push(v, t);
    tick();
    push_vld = 1'b0;
  endtask

  task automatic req_pulse(input int c);
    core_req[c] = 1'b1;
    tick();
    core_req[c] = 1'b0;
  endtask

  typedef struct packed {
    logic req, ev, clr;
    logic [31:0] val;
    logic gnt, ack, rv;
    logic [31:0] rdata;
    logic [15:0] cnt;
  } vec_t;

  function automatic vec_t mk(logic rq, logic e, logic [31:0] v, logic cl, logic g,
                              logic a, logic r, logic [31:0] rd, logic [15:0] cn);
    vec_t x;
    x.req = rq; x.ev = e; x.val = v; x.clr = cl;
    x.gnt = g; x.ack = a; x.rv = r; x.rdata = rd; x.cnt = cn;
    return x;
  endfunction

  vec_t tv [14];
  int   t0;
  logic [3:0] gs;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // core0 cycle vectors, dispatch inputs driven directly
    tv[0]  = mk(1, 1, 32'h55,   0, 1, 0, 0, 32'h0,    0);
    tv[1]  = mk(0, 0, 32'h0,    0, 0, 0, 0, 32'h0,    0);
    tv[2]  = mk(1, 0, 32'h0,    0, 0, 0, 0, 32'h0,    1);
    tv[3]  = mk(1, 1, 32'hDEAD, 0, 0, 1, 0, 32'h0,    2);
    tv[4]  = mk(1, 1, 32'hBEEF, 0, 0, 0, 1, 32'hDEAD, 3);
    tv[5]  = mk(1, 1, 32'hBEEF, 0, 1, 0, 0, 32'hDEAD, 3);
    tv[6]  = mk(0, 1, 32'h77,   1, 0, 1, 0, 32'hDEAD, 3);
    tv[7]  = mk(0, 0, 32'h0,    0, 0, 0, 1, 32'h77,   0);
    tv[8]  = mk(0, 0, 32'h0,    0, 0, 0, 0, 32'h77,   0);
    tv[9]  = mk(1, 0, 32'h0,    0, 1, 0, 0, 32'h77,   0);
    tv[10] = mk(0, 0, 32'h0,    1, 0, 0, 0, 32'h77,   0);
    tv[11] = mk(0, 1, 32'h1,    0, 0, 1, 0, 32'h77,   0);
    tv[12] = mk(0, 0, 32'h0,    0, 0, 0, 1, 32'h1,    1);
    tv[13] = mk(0, 0, 32'h0,    0, 0, 0, 0, 32'h1,    1);

    do_reset();
    @(negedge clk_i);
    chk("reset_outputs", {gnt, rv, pop, ack}, 0);
    chk("reset_rdata", |rdata, 0);
    chk("reset_cnt", |cnt, 0);
    tick();

    for (int i = 0; i < 14; i++) begin
      core_req[0] = tv[i].req;
      tbl_ev[0]   = tv[i].ev;
      tbl_val[0]  = tv[i].val;
      stat_clr[0] = tv[i].clr;
      @(negedge clk_i);
      chk($sformatf("vec%0d_gnt", i), gnt[0], tv[i].gnt);
      chk($sformatf("vec%0d_pop_req", i), pop[0], tv[i].gnt);
      chk($sformatf("vec%0d_ack", i), ack[0], tv[i].ack);
      chk($sformatf("vec%0d_rvalid", i), rv[0], tv[i].rv);
      chk($sformatf("vec%0d_rdata", i), rdata[0], tv[i].rdata);
      chk($sformatf("vec%0d_cnt", i), cnt[0], tv[i].cnt);
      tick();
    end
    tbl_ev = '0;
    model_en = 1'b1;
    chk_en   = 1'b1;

    // 1: value present -> gnt t0, ack t0+1, rvalid t0+2, cnt=1
    do_reset();
    push(32'hCAFE0001, 4'b0001);
    clear_logs();
    t0 = cyc;
    req_pulse(0);
    repeat (4) tick();
    chk("s1_pops", pop_log[0].size(), 1);
    chk("s1_pop_t", (pop_log[0].size() > 0) ? pop_log[0][0] - t0 : -1, 0);
    chk("s1_ack_t", (ack_log[0].size() > 0) ? ack_log[0][0] - t0 : -1, 1);
    chk("s1_rdata", (rv_log[0].size() > 0) ? rv_log[0][0] : 32'hX, 32'hCAFE0001);
    chk("s1_cnt", cnt[0], 1);

    // 2: long wait before value arrives
    do_reset();
    clear_logs();
    req_pulse(1);
    repeat (20) tick();
    push(32'h12345678, 4'b0010);
    for (int k = 0; k < 10 && rv_log[1].size() == 0; k++) tick();
    chk("s2_rvalid_seen", rv_log[1].size(), 1);
    chk("s2_rdata", (rv_log[1].size() > 0) ? rv_log[1][0] : 32'hX, 32'h12345678);
    chk("s2_acks", ack_log[1].size(), 1);
    chk("s2_cnt_ge20", cnt[1] >= 20, 1);

    // 3: held request, back-to-back pops 3 cycles apart
    do_reset();
    push(32'hA, 4'b1111);
    push(32'hB, 4'b1111);
    clear_logs();
    core_req[0] = 1'b1;
    repeat (5) tick();
    core_req[0] = 1'b0;
    repeat (4) tick();
    chk("s3_pops", pop_log[0].size(), 2);
    chk("s3_spacing", (pop_log[0].size() == 2) ? pop_log[0][1] - pop_log[0][0] : -1, 3);
    chk("s3_first", (rv_log[0].size() > 0) ? rv_log[0][0] : 32'hX, 32'hA);
    chk("s3_second", (rv_log[0].size() > 1) ? rv_log[0][1] : 32'hX, 32'hB);

    // 4: team filtering
    do_reset();
    push(32'h11, 4'b0100);
    push(32'h22, 4'b1111);
    clear_logs();
    req_pulse(0);
    repeat (6) tick();
    req_pulse(2);
    repeat (6) tick();
    req_pulse(2);
    repeat (6) tick();
    chk("s4_core0", (rv_log[0].size() == 1) ? rv_log[0][0] : 32'hX, 32'h22);
    chk("s4_core2_n", rv_log[2].size(), 2);
    chk("s4_core2_a", (rv_log[2].size() > 0) ? rv_log[2][0] : 32'hX, 32'h11);
    chk("s4_core2_b", (rv_log[2].size() > 1) ? rv_log[2][1] : 32'hX, 32'h22);

    // 5: reset while core3 waits
    do_reset();
    push(32'h99, 4'b1000);
    req_pulse(3);
    repeat (5) tick();
    req_pulse(3);
    repeat (3) tick();
    core_req[3] = 1'b1;
    rst_ni = 1'b0;
    #2;
    chk("s5_rst_ctrl", {gnt, rv, pop, ack}, 0);
    chk("s5_rst_rdata", |rdata, 0);
    chk("s5_rst_cnt", |cnt, 0);
    for (int c = 0; c < 4; c++) exp_q[c].delete();
    clear_logs();
    repeat (2) tick();
    rst_ni = 1'b1;
    tick();
    core_req[3] = 1'b0;
    repeat (4) tick();
    chk("s5_pops", pop_log[3].size(), 1);
    chk("s5_no_ack", ack_log[3].size(), 0);
    push(32'h33, 4'b1000);
    repeat (5) tick();
    chk("s5_acks", ack_log[3].size(), 1);
    chk("s5_rdata", (rv_log[3].size() > 0) ? rv_log[3][0] : 32'hX, 32'h33);

    // 6: saturation of narrow counter and clear during WAIT
    do_reset();
    req_pulse(2);
    repeat (40) tick();
    stat_clr[2] = 1'b1;
    @(negedge clk_i);
    chk("s6_cnt16", cnt[2], 40);
    chk("s6_cnt4_sat", cnt4[2], 15);
    tick();
    stat_clr[2] = 1'b0;
    @(negedge clk_i);
    chk("s6_clr16", cnt[2], 0);
    chk("s6_clr4", cnt4[2], 0);
    tick();
    push(32'h44, 4'b0100);
    repeat (5) tick();

    // randomized traffic against the reference
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk_i);
      gs = gnt;
      tick();
      for (int c = 0; c < 4; c++) begin
        if (!core_req[c] || gs[c]) core_req[c] = ($urandom_range(3) == 0);
        stat_clr[c] = ($urandom_range(39) == 0);
      end
      if ($urandom_range(4) == 0) set_push($urandom, 4'($urandom_range(15, 1)));
      else push_vld = 1'b0;
    end
    core_req = '0;
    stat_clr = '0;
    push_vld = 1'b0;
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
